seq_det_sched: RTL
==================

Name: seq_det_sched

Overview:
Time-multiplexes one "1101" Mealy sequence-detector next-state function across NUM_CH independent serial bit streams. Each channel keeps its own 2-bit detector context. A round-robin arbiter grants one channel per cycle, and the granted bit is applied to that channel's context. Detections are reported with channel id one cycle later, and per-channel hit counts are kept for readout. It sits between the serial front-ends and the status/interrupt logic.

Parameters:
NUM_CH, 4, number of requesting channels (2..16); CH_W = $clog2(NUM_CH) is a derived localparam.
CNT_W, 8, width of each per-channel saturating hit counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  NUM_CH  per-channel request; bit_in[k] is valid while req[k]=1
bit_in  input  NUM_CH  per-channel serial data bit
gnt  output  NUM_CH  one-hot combinational grant; bit_in[k] is consumed in the cycle gnt[k]=1
flush  input  1  clear context and counter of channel flush_ch
flush_ch  input  CH_W  channel selected by flush
det_valid  output  1  registered one-cycle pulse: pattern completed
det_ch  output  CH_W  registered channel of the detection; holds its last value when det_valid=0
rd_ch  input  CH_W  counter readout select
rd_cnt  output  CNT_W  combinational hit count of channel rd_ch

Behaviour:
- Reset: clock and reset are one clock and a synchronous, active-high reset. rst=1 at a clock edge sets:
  - all contexts to IDLE and all counters to 0
  - rr_ptr to NUM_CH-1, so channel 0 wins first
  - det_valid=0 and det_ch=0
  gnt is forced to 0 while rst=1. Reset mid-stream discards partial patterns, with no detection.
- Arbitration: round-robin. Search starts at rr_ptr+1 (mod NUM_CH); the first channel with req=1 is granted. rr_ptr updates to the granted index on the same edge. No req means gnt=0 and rr_ptr holds.
- Requester rule: hold req and bit_in stable until gnt is seen. Dropping req without a grant is legal; nothing is consumed.
- Detector (overlapping "1101"). States: IDLE=2'b00, S1=2'b01, S11=2'b10, S110=2'b11. Transitions on the granted bit i:
  - IDLE: 1 to S1; 0 to IDLE.
  - S1: 1 to S11; 0 to IDLE.
  - S11: 1 to S11; 0 to S110.
  - S110: 1 to S1 with hit=1; 0 to IDLE.
  Only the granted channel's context updates; all other contexts hold.
- Latency: hit in grant cycle t gives det_valid=1 and det_ch=k at edge t+1. One detection per cycle maximum.
- Counter: on a hit, cnt[k] increments and saturates at 2^CNT_W-1, with no wrap.
- Flush: flush=1 sets ctx[flush_ch]=IDLE and cnt[flush_ch]=0 at the edge.
  - The flushed channel is masked out of arbitration that cycle: gnt[flush_ch]=0, and another requester may win.
  - Flush never produces det_valid.
  - flush_ch >= NUM_CH is ignored.
- rd_ch >= NUM_CH reads 0. A readout of a channel updating this cycle returns the pre-edge value.

Optional Feature:
SEQ_DET_SCHED_CNT_EN.
- Defined: hit counters and rd_cnt are implemented as above.
- Undefined: no counter flops; rd_cnt is tied to 0.
- Port list is identical in both builds.

Decomposition:
- Package seq_det_pkg:
  - det_state_t enum: IDLE, S1, S11, S110 (2-bit encodings as above)
  - PATTERN constant 4'b1101
  - rr_next() function for the round-robin search
- One sub-module, seq_det_core: purely combinational. Inputs state and i; outputs next_state and hit. Instantiated once, fed through a mux on the granted context.
- Contexts, arbiter, counters and output registers live in seq_det_sched.

Test Plan:
1. Single stream: only ch2 requests, bits 1,1,0,1 on successive grants. Expect det_valid=1 and det_ch=2 exactly one cycle after the 4th grant; rd_ch=2 gives rd_cnt=1.
2. Fairness: req=4'b1111 held constant. Expect gnt sequence 0001, 0010, 0100, 1000, 0001; with req=4'b1010, expect alternating 0010/1000.
3. Interleave: ch0 and ch1 both requesting, each fed 1,1,0,1 on its own grants. Expect two detections, det_ch=0 then det_ch=1, one cycle apart; each count is 1.
4. Overlap: ch1 stream 1,1,0,1,1,0,1. Expect 2 detections (after grants 4 and 7); ch1 ends in S1.
5. Flush: ch3 fed 1,1,0, then flush with flush_ch=3 while req[3]=1. Expect gnt[3]=0 that cycle. Then feeding 1 gives no detection; cnt[3]=0.
6. Saturation/reset, with CNT_W=2:
   - 5 patterns on ch0: rd_cnt saturates at 3.
   - Assert rst mid-pattern: gnt=0 during reset; after release, state IDLE and counts 0; the first grant goes to ch0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the time-multiplexed "1101" detector.
//   det_state_t : 2-bit detector context encoding (IDLE, S1, S11, S110)
//   PATTERN     : the overlapping pattern being detected, oldest bit first
//   rr_next()   : round-robin search over up to 16 requesters
// Optional feature macro used by the top: SEQ_DET_SCHED_CNT_EN.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      S1   = 2'b01,
      S11  = 2'b10,
      S110 = 2'b11
   } det_state_t;

   localparam logic [3:0] PATTERN = 4'b1101;

   // Search starts one past ptr and wraps modulo n. Returns {found, index};
   // when nothing requests, the index is ptr so the caller can leave it alone.
   function automatic logic [4:0] rr_next(input logic [15:0] req,
                                          input logic [3:0]  ptr,
                                          input int          n);
      logic       found;
      logic [3:0] idx;
      int         c;
      found = 1'b0;
      idx   = ptr;
      for (int k = 1; k <= 16; k++) begin
         c = (int'(ptr) + k) % n;
         if (k <= n && !found && req[c]) begin
            found = 1'b1;
            idx   = 4'(c);
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: combinational next-state function of one overlapping "1101"
// Mealy detector. Shared by all channels through a mux on the granted context.
// Ports:
//   state      in  2  current context of the granted channel
//   i          in  1  granted serial bit
//   next_state out 2  context to write back
//   hit        out 1  pattern completed on this bit
module seq_det_core
   import seq_det_pkg::*;
(
   input  logic [1:0] state,
   input  logic       i,
   output logic [1:0] next_state,
   output logic       hit
);

   det_state_t cur;
   det_state_t nxt;

   always_comb begin
      cur = det_state_t'(state);
      nxt = IDLE;
      hit = 1'b0;
      case (cur)
         IDLE: nxt = i ? S1  : IDLE;
         S1:   nxt = i ? S11 : IDLE;
         S11:  nxt = i ? S11 : S110;
         S110: begin
            // Completing bit; the trailing '1' is also a new prefix (overlap).
            hit = (i == PATTERN[0]);
            nxt = hit ? S1 : IDLE;
         end
         default: nxt = IDLE;
      endcase
      next_state = nxt;
   end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: one "1101" detector shared round-robin across NUM_CH serial
// streams. Each channel keeps its own 2-bit context; one channel is granted per
// cycle and its bit advances its context. Detections are reported one cycle
// later with the channel id; per-channel saturating hit counters are readable.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req        per-channel request; bit_in[k] valid while req[k]=1
//   bit_in     per-channel serial bit
//   gnt        one-hot combinational grant (bit consumed when gnt[k]=1)
//   flush      clear context/counter of flush_ch (ignored if out of range)
//   flush_ch   channel selected by flush
//   det_valid  registered one-cycle detection pulse
//   det_ch     registered channel of last detection
//   rd_ch      counter readout select
//   rd_cnt     combinational hit count of rd_ch (0 when out of range)
// Macro SEQ_DET_SCHED_CNT_EN: when defined the hit counters exist; otherwise
// rd_cnt is tied to 0. Handshake: a requester holds req and bit_in stable until
// it sees gnt; dropping req without a grant consumes nothing.
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 8,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] bit_in,
   output logic [NUM_CH-1:0] gnt,
   input  logic              flush,
   input  logic [CH_W-1:0]   flush_ch,
   output logic              det_valid,
   output logic [CH_W-1:0]   det_ch,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [CNT_W-1:0]  rd_cnt
);

   logic [1:0]        ctx [NUM_CH];
   logic [CH_W-1:0]   rr_ptr;
   logic              flush_ok;
   logic [NUM_CH-1:0] flush_mask;
   logic [15:0]       req16;
   logic [4:0]        rr_res;
   logic              gnt_found;
   logic [CH_W-1:0]   gnt_idx;
   logic [1:0]        core_next;
   logic              core_hit;

   // Flushed channel is removed from this cycle's arbitration.
   always_comb begin
      flush_ok   = flush && (int'(flush_ch) < NUM_CH);
      flush_mask = '0;
      if (flush_ok) flush_mask[flush_ch] = 1'b1;
   end

   always_comb begin
      req16               = '0;
      req16[NUM_CH-1:0]   = req & ~flush_mask;
      rr_res              = rr_next(req16, 4'(rr_ptr), NUM_CH);
      gnt_found           = rr_res[4] & ~rst;
      gnt_idx             = rr_res[CH_W-1:0];
      gnt                 = '0;
      if (gnt_found) gnt[gnt_idx] = 1'b1;
   end

   seq_det_core u_core (
      .state      (ctx[gnt_idx]),
      .i          (bit_in[gnt_idx]),
      .next_state (core_next),
      .hit        (core_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) ctx[k] <= IDLE;
         rr_ptr    <= CH_W'(NUM_CH - 1);
         det_valid <= 1'b0;
         det_ch    <= '0;
      end else begin
         det_valid <= 1'b0;
         if (gnt_found) begin
            ctx[gnt_idx] <= core_next;
            rr_ptr       <= gnt_idx;
            if (core_hit) begin
               det_valid <= 1'b1;
               det_ch    <= gnt_idx;
            end
         end
         // Never collides with the grant write: the flushed channel is masked.
         if (flush_ok) ctx[flush_ch] <= IDLE;
      end
   end

`ifdef SEQ_DET_SCHED_CNT_EN
   logic [CNT_W-1:0] cnt [NUM_CH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
      end else begin
         if (gnt_found && core_hit && (cnt[gnt_idx] != '1))
            cnt[gnt_idx] <= cnt[gnt_idx] + CNT_W'(1);
         if (flush_ok) cnt[flush_ch] <= '0;
      end
   end

   // Reads the pre-edge value even when the channel updates this cycle.
   always_comb begin
      rd_cnt = '0;
      if (int'(rd_ch) < NUM_CH) rd_cnt = cnt[rd_ch];
   end
`else
   logic unused_rd;
   assign unused_rd = ^rd_ch;
   assign rd_cnt    = '0;
`endif

endmodule
